// File: rtl/dpsk_pkg.sv
// Shared defaults and helpers for the DPSK symbol demodulator.
// The decision polarity lives here so the transmit and receive ends agree on it.
package dpsk_pkg;

   localparam int   DW_DEFAULT  = 10;
   localparam int   SPS_DEFAULT = 16;
   localparam logic FLIP_IS_ONE = 1'b1;

   // A sum of sps samples of dw bits needs log2(sps) extra bits of headroom.
   function automatic int calc_aw(input int dw, input int sps);
      return dw + $clog2(sps);
   endfunction

endpackage

// File: rtl/dpsk_sym_integrator.sv
// Integrates accepted I/Q samples over one symbol period and registers the symbol sums.
// sym_done pulses for one enabled cycle when cur_i/cur_q take a new symbol.
module dpsk_sym_integrator
   import dpsk_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int SPS = SPS_DEFAULT,
   parameter int AW  = calc_aw(DW, SPS),
   localparam int CW = $clog2(SPS)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clken,
   input  logic          in_valid,
   input  logic [DW-1:0] i_in,
   input  logic [DW-1:0] q_in,
   input  logic          sym_sync,
   output logic [CW-1:0] sym_cnt,
   output logic [AW-1:0] cur_i,
   output logic [AW-1:0] cur_q,
   output logic          sym_done
);

   logic signed [AW-1:0] samp_i, samp_q;
   logic signed [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
   logic signed [AW-1:0] cur_i_q, cur_i_d, cur_q_q, cur_q_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 done_q, done_d;

   assign samp_i = {{(AW-DW){i_in[DW-1]}}, i_in};
   assign samp_q = {{(AW-DW){q_in[DW-1]}}, q_in};

   // Only evaluated on enabled edges; sync beats the end-of-symbol path.
   always_comb begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      cur_i_d = cur_i_q;
      cur_q_d = cur_q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (sym_sync) begin
         if (in_valid) begin
            acc_i_d = samp_i;
            acc_q_d = samp_q;
            cnt_d   = CW'(1);
         end else begin
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
         end
      end else if (in_valid) begin
         if (cnt_q == CW'(SPS-1)) begin
            cur_i_d = acc_i_q + samp_i;
            cur_q_d = acc_q_q + samp_q;
            acc_i_d = '0;
            acc_q_d = '0;
            cnt_d   = '0;
            done_d  = 1'b1;
         end else begin
            acc_i_d = acc_i_q + samp_i;
            acc_q_d = acc_q_q + samp_q;
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         acc_i_q <= '0;
         acc_q_q <= '0;
         cur_i_q <= '0;
         cur_q_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else if (clken) begin
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
         cur_i_q <= cur_i_d;
         cur_q_q <= cur_q_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   assign sym_cnt  = cnt_q;
   assign cur_i    = cur_i_q;
   assign cur_q    = cur_q_q;
   assign sym_done = done_q;

endmodule

// File: rtl/dpsk_demod.sv
// DPSK demodulator: dot product of consecutive symbol sums, one hard bit per symbol.
// in_valid has no back-pressure: a sample is consumed on every edge with clken & in_valid; bit_valid is a one-enabled-cycle strobe.
module dpsk_demod
   import dpsk_pkg::*;
#(
   parameter int DW  = DW_DEFAULT,
   parameter int SPS = SPS_DEFAULT,
   parameter int AW  = calc_aw(DW, SPS)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    clken,
   input  logic                    in_valid,
   input  logic [DW-1:0]           i_in,
   input  logic [DW-1:0]           q_in,
   input  logic                    sym_sync,
   output logic                    bit_out,
   output logic                    bit_valid,
   output logic [2*AW:0]           dot_out,
   output logic [$clog2(SPS)-1:0]  sym_cnt
);

   logic [AW-1:0]          cur_i_w, cur_q_w;
   logic                   sym_done;
   logic signed [AW-1:0]   cur_i, cur_q;
   logic signed [AW-1:0]   prev_i_q, prev_i_d, prev_q_q, prev_q_d;
   logic                   have_ref_q, have_ref_d;
   logic signed [2*AW-1:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
   logic                   prod_valid_q, prod_valid_d;
   logic signed [2*AW:0]   dot_q, dot_d;
   logic                   bit_q, bit_d;
   logic                   bit_valid_q, bit_valid_d;

   dpsk_sym_integrator #(
      .DW  (DW),
      .SPS (SPS),
      .AW  (AW)
   ) u_integrator (
      .clk      (clk),
      .reset_n  (reset_n),
      .clken    (clken),
      .in_valid (in_valid),
      .i_in     (i_in),
      .q_in     (q_in),
      .sym_sync (sym_sync),
      .sym_cnt  (sym_cnt),
      .cur_i    (cur_i_w),
      .cur_q    (cur_q_w),
      .sym_done (sym_done)
   );

   assign cur_i = $signed(cur_i_w);
   assign cur_q = $signed(cur_q_w);

   // The first symbol after reset only seeds the reference; products use the old prev.
   always_comb begin
      prev_i_d     = prev_i_q;
      prev_q_d     = prev_q_q;
      have_ref_d   = have_ref_q;
      prod_i_d     = prod_i_q;
      prod_q_d     = prod_q_q;
      prod_valid_d = 1'b0;
      dot_d        = dot_q;
      bit_d        = bit_q;
      bit_valid_d  = 1'b0;
      if (sym_done) begin
         prev_i_d   = cur_i;
         prev_q_d   = cur_q;
         have_ref_d = 1'b1;
         if (have_ref_q) begin
            prod_i_d     = cur_i * prev_i_q;
            prod_q_d     = cur_q * prev_q_q;
            prod_valid_d = 1'b1;
         end
      end
      if (prod_valid_q) begin
         dot_d       = {prod_i_q[2*AW-1], prod_i_q} + {prod_q_q[2*AW-1], prod_q_q};
         bit_d       = dot_d[2*AW] ? FLIP_IS_ONE : ~FLIP_IS_ONE;
         bit_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         prev_i_q     <= '0;
         prev_q_q     <= '0;
         have_ref_q   <= 1'b0;
         prod_i_q     <= '0;
         prod_q_q     <= '0;
         prod_valid_q <= 1'b0;
         dot_q        <= '0;
         bit_q        <= 1'b0;
         bit_valid_q  <= 1'b0;
      end else if (clken) begin
         prev_i_q     <= prev_i_d;
         prev_q_q     <= prev_q_d;
         have_ref_q   <= have_ref_d;
         prod_i_q     <= prod_i_d;
         prod_q_q     <= prod_q_d;
         prod_valid_q <= prod_valid_d;
         dot_q        <= dot_d;
         bit_q        <= bit_d;
         bit_valid_q  <= bit_valid_d;
      end
   end

   assign dot_out   = dot_q;
   assign bit_out   = bit_q;
   assign bit_valid = bit_valid_q;

endmodule
